// File: rtl/dct_pkg.sv
// Shared types and constants for the 2-D DCT datapath blocks.
package dct_pkg;

   localparam int unsigned N      = 8;
   localparam int unsigned COEF_W = 16;

   typedef logic [2:0]               idx_t;
   typedef logic signed [COEF_W-1:0] vec_t [N];

   function automatic logic is_last(input idx_t i);
      return i == idx_t'(N - 1);
   endfunction

endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 coefficient bank: row-wide write port, combinational column read.
module dct_tp_bank
   import dct_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [2:0]            wr_row,
   input  logic [N*DATA_W-1:0]   wr_vec,
   input  logic [2:0]            rd_col,
   output logic [N*DATA_W-1:0]   rd_vec
);

   logic [DATA_W-1:0] mem [N][N];

   // Contents are deliberately not reset; full flags in the parent gate validity.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned c = 0; c < N; c++) begin
            mem[wr_row][c] <= wr_vec[c*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rd_vec = '0;
      for (int unsigned r = 0; r < N; r++) begin
         rd_vec[r*DATA_W +: DATA_W] = mem[r][rd_col];
      end
   end

endmodule

// File: rtl/dct_transpose8x8.sv
// Ping-pong 8x8 transpose buffer between the row-pass and column-pass DCT cores.
module dct_transpose8x8
   import dct_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DATA_W-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N*DATA_W-1:0]   out_data,
   output logic                  out_last
);

   logic        wr_bank;
   logic        rd_bank;
   idx_t        wr_row;
   idx_t        rd_col;
   logic [1:0]  full;
   logic [1:0]  full_set;
   logic [1:0]  full_clr;
   logic        wr_fire;
   logic        rd_fire;
   logic [N*DATA_W-1:0] bank_rd [2];

   assign in_ready  = !full[wr_bank];
   assign out_valid = full[rd_bank];
   assign out_last  = out_valid && is_last(rd_col);
   assign out_data  = bank_rd[rd_bank];

   assign wr_fire = in_valid && in_ready;
   assign rd_fire = out_valid && out_ready;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      dct_tp_bank #(.DATA_W(DATA_W)) u_bank (
         .clk    (clk),
         .we     (wr_fire && (wr_bank == 1'(b))),
         .wr_row (wr_row),
         .wr_vec (in_data),
         .rd_col (rd_col),
         .rd_vec (bank_rd[b])
      );
   end

   // Set and clear always hit different banks, so applying both in one edge is safe.
   always_comb begin
      full_set = '0;
      full_clr = '0;
      if (wr_fire && is_last(wr_row)) full_set[wr_bank] = 1'b1;
      if (rd_fire && is_last(rd_col)) full_clr[rd_bank] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_row  <= '0;
         rd_col  <= '0;
         full    <= '0;
      end else begin
         if (wr_fire) begin
            wr_row <= wr_row + idx_t'(1);
            if (is_last(wr_row)) wr_bank <= !wr_bank;
         end
         if (rd_fire) begin
            rd_col <= rd_col + idx_t'(1);
            if (is_last(rd_col)) rd_bank <= !rd_bank;
         end
         full <= (full | full_set) & ~full_clr;
      end
   end

endmodule

// File: doc/dct_transpose8x8.md
# dct_transpose8x8

Ping-pong 8×8 transpose buffer between the row-pass and column-pass 8-point Chen DCT cores of the 2-D DCT. It accepts eight row-DCT coefficient vectors, one per handshake, and emits the same block column by column so the second 1-D DCT sees columns. Two banks let one block be written while the previous block is read, sustaining one vector per cycle. It uses the same valid/ready conventions as the DCT cores on both sides.

## Interface
- DATA_W, 16, coefficient width in bits; samples pass through unmodified.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an input row is presented.
- in_ready  out  1  the buffer can accept a row.
- in_data  in  8×DATA_W  row vector; element c is column c of the current row.
- out_valid  out  1  an output column is presented.
- out_ready  in  1  the downstream DCT accepts the column.
- out_data  out  8×DATA_W  column vector; element r is row r of the current column.
- out_last  out  1  the current output is column 7 of a block.

## Operation
- Storage: two banks of 8×8×DATA_W registers. Each bank has a full flag.
- Write side state: wr_bank (1 bit) and wr_row (3 bits).
  - A write fires when in_valid && in_ready. The write stores in_data into bank[wr_bank] row wr_row, then increments wr_row.
  - When wr_row==7 and the write fires: set full[wr_bank], toggle wr_bank, wrap wr_row to 0.
  - in_ready = !full[wr_bank].
- Read side state: rd_bank (1 bit) and rd_col (3 bits).
  - out_valid = full[rd_bank].
  - out_data[r] = bank[rd_bank][r][rd_col].
  - out_last = out_valid && rd_col==7.
  - A read fires when out_valid && out_ready. It increments rd_col.
  - When rd_col==7 and the read fires: clear full[rd_bank], toggle rd_bank, wrap rd_col to 0.
- Bank state per bank: EMPTY → FILLING (wr_bank points at it, wr_row>0) → FULL → DRAINING (rd_bank points at it, rd_col>0) → EMPTY.
- Simultaneous events: the set and clear of full flags always target different banks, so both take effect in the same cycle. The one exception is a one-bank degenerate case, which cannot occur because in_ready is low on a full bank.
- Both banks full: in_ready=0. Writing resumes the cycle after the last column of rd_bank is read.
- Both banks empty: out_valid=0, in_ready=1.
- in_data is ignored when the write does not fire. out_data is don't-care when out_valid=0.
- Outputs must be stable while out_valid && !out_ready.

## Timing
- Reset state (asynchronous assertion, synchronous deassertion handled upstream):
  - wr_bank=rd_bank=0, wr_row=rd_col=0, both full flags 0.
  - Resulting outputs: in_ready=1, out_valid=0, out_last=0. Bank contents are not reset.
- Reset mid-block discards both partial and full blocks. No output is produced for them.
- Latency: a full flag is registered, so out_valid rises in the cycle after the clock edge that accepts row 7. This is 8 cycles after the first row handshake when rows arrive back-to-back.
- Throughput:
  - With in_valid=out_ready=1 continuously, there are no in_ready bubbles.
  - Block n+1 rows are written while block n columns are read.
- in_ready, out_valid and out_last are functions of registers only. There is no combinational path from out_ready to in_ready or from in_valid to out_valid.

## Structure
- Shared package dct_pkg:
  - localparam N=8.
  - typedef vec_t (array [N] of logic signed [DATA_W-1:0]).
  - typedef idx_t (logic [2:0]).
- Sub-module dct_tp_bank: one 8×8 bank with a row-write port (we, row index, vector) and a combinational column-read port (column index → vector). The top instantiates it twice and holds the control counters and full flags.
- Target: about 150–250 lines total.

## Test plan
- Single block: rows r=0..7 with element c = 16·r+c, out_ready=1 → 8 columns starting the cycle after row 7. Column c element r = 16·r+c. out_last high only on column 7.
- Back-to-back blocks, out_ready=1: three blocks streamed continuously → in_ready never drops, 24 columns in order, one per cycle after the initial 8-cycle latency.
- Backpressure: out_ready=0, three blocks offered → in_ready falls after 16 rows accepted. Raising out_ready drains block 0; in_ready returns the cycle after column 7 is read.
- Stalls: random in_valid and out_ready at 50% over 20 blocks → output matches a transpose model. out_data is held steady during every stall.
- Reset mid-operation: assert rst_n=0 after 5 rows of block 1 while block 0 is draining → out_valid=0 and in_ready=1 immediately. A fresh block afterwards transposes correctly.
- Extreme values: entries 0x8000 and 0x7FFF in a checkerboard → bit-exact transpose with no sign or width corruption.
